// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: narrows the 32-bit store value to byte/half/word and writes it
// into its little-endian lane of a word-wide data memory over a req/ack interface.
// Default build performs read-modify-write (RD then WR) for byte/half stores.
// Optional macro SNR_BYTE_STROBE_EN: adds mem_be, skips RD, writes replicated data.
module store_narrow_rmw #(
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef SNR_BYTE_STROBE_EN
  output logic [3:0]        mem_be,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept_c;
  logic                reject_c;

`ifdef SNR_BYTE_STROBE_EN
  logic [3:0]          mem_be_q, mem_be_d;
  logic                unused_rdata_c;
  assign unused_rdata_c = ^mem_rdata;
`else
  logic [1:0]          size_q, size_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]   merged_c;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign accept_c  = req_valid & req_ready;

  // Reserved size, or a half/word not aligned to its own width, is rejected.
  always_comb begin
    reject_c = 1'b1;
    unique case (req_size)
      SZ_BYTE: reject_c = 1'b0;
      SZ_HALF: reject_c = req_addr[0];
      SZ_WORD: reject_c = |req_addr[1:0];
      default: reject_c = 1'b1;
    endcase
  end

`ifndef SNR_BYTE_STROBE_EN
  // Overlay the narrowed store data on the word returned by the read phase.
  always_comb begin
    merged_c = mem_rdata;
    if (size_q == SZ_HALF) begin
      merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end
`endif

  // Next-state: rejects go straight to DONE; full words (or any store with strobes) skip RD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (reject_c) begin
            state_d = S_DONE;
`ifdef SNR_BYTE_STROBE_EN
          end else begin
            state_d = S_WR;
          end
`else
          end else if (req_size == SZ_WORD) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
`endif
        end
      end
      S_RD:    if (mem_ack) state_d = S_WR;
      S_WR:    if (mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes/done decoded from the next state, data latched at accept or read ack.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = (state_d == S_RD);
    mem_wr_d    = (state_d == S_WR);
    done_d      = (state_d == S_DONE);
    err_d       = accept_c & reject_c;
`ifdef SNR_BYTE_STROBE_EN
    mem_be_d    = mem_be_q;
    if (accept_c && !reject_c) begin
      mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
      unique case (req_size)
        SZ_BYTE: begin
          mem_be_d    = 4'b0001 << req_addr[1:0];
          mem_wdata_d = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          mem_be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_be_d    = 4'b1111;
          mem_wdata_d = req_wdata;
        end
      endcase
    end
`else
    size_d      = size_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    if (accept_c && !reject_c) begin
      mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d = req_wdata;
      size_d      = req_size;
      lane_d      = req_addr[1:0];
      wdata_d     = req_wdata[15:0];
    end
    if ((state_q == S_RD) && mem_ack) begin
      mem_wdata_d = merged_c;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SNR_BYTE_STROBE_EN
      mem_be_q    <= 4'b0000;
`else
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0000;
`endif
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SNR_BYTE_STROBE_EN
      mem_be_q    <= mem_be_d;
`else
      size_q      <= size_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef SNR_BYTE_STROBE_EN
  assign mem_be    = mem_be_q;
`endif

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: directed stores against a byte-lane memory model,
// a behavioural memory responder, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_store_narrow_rmw;

  localparam int unsigned ADDR_W = 32;
`ifdef SNR_BYTE_STROBE_EN
  localparam bit STROBE = 1'b1;
`else
  localparam bit STROBE = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              done;
  logic              err;
`ifdef SNR_BYTE_STROBE_EN
  logic [3:0]        mem_be;
  logic [3:0]        last_be;
`endif

  store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
`ifdef SNR_BYTE_STROBE_EN
    .mem_be    (mem_be),
`endif
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned cyc;
  bit          in_flight;
  bit          spur;
  int unsigned ack_dly;
  int unsigned wcnt;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wd;
  logic [31:0] cur_old;
  int unsigned rd_cycles;
  int unsigned wr_cycles;
  int unsigned done_cnt;
  logic [31:0] last_wdata;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sz_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic [1:0] s, input logic [31:0] a);
    return (s != 2'd3) && ((int'(a[1:0]) % sz_bytes(s)) == 0);
  endfunction

  // number of memory strobe phases the store needs
  function automatic int phases(input logic [1:0] s, input logic [31:0] a);
    if (!legal(s, a)) return 0;
    return (!STROBE && s != 2'd2) ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] old, input logic [1:0] s,
                                             input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    int n;
    int lane;
    n    = sz_bytes(s);
    lane = int'(a[1:0]);
    for (int j = 0; j < 4; j++) b[j] = old[8*j +: 8];
    if (STROBE) begin
      for (int j = 0; j < 4; j++) b[j] = wd[8*(j % n) +: 8];
    end else begin
      for (int i = 0; i < n; i++) b[lane + i] = wd[8*i +: 8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] be;
    int lane;
    be   = 4'b0000;
    lane = int'(a[1:0]);
    for (int i = 0; i < sz_bytes(s); i++) be[2'(lane + i)] = 1'b1;
    return be;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    wcnt      = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt      = 0;
      end
      if (!rst_n) begin
        wcnt = 0;
      end else if (spur) begin
        if (!mem_rd && !mem_wr) mem_ack = 1'b1;
        spur = 1'b0;
      end else if (mem_rd || mem_wr) begin
        if (wcnt == ack_dly) begin
          mem_ack = 1'b1;
          if (mem_rd) mem_rdata = cur_old;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 32'(req_ready), 32'(!in_flight));
      if (!in_flight) begin
        check("idle_quiet", {28'h0, mem_rd, mem_wr, done, err}, 32'h0);
      end else begin
        if (mem_rd) begin
          rd_cycles++;
          check("rd_expected", 32'(phases(cur_size, cur_addr)), 32'd2);
          check("rd_excl", 32'(mem_wr), 32'd0);
          check("rd_addr", mem_addr, {cur_addr[31:2], 2'b00});
        end
        if (mem_wr) begin
          wr_cycles++;
          last_wdata = mem_wdata;
          check("wr_expected", 32'(legal(cur_size, cur_addr)), 32'd1);
          check("wr_addr", mem_addr, {cur_addr[31:2], 2'b00});
          check("wr_data", mem_wdata, model_word(cur_old, cur_size, cur_addr, cur_wd));
`ifdef SNR_BYTE_STROBE_EN
          last_be = mem_be;
          check("wr_be", 32'(mem_be), 32'(model_be(cur_size, cur_addr)));
`endif
        end
        if (done) begin
          done_cnt++;
          last_err = err;
          check("err_flag", 32'(err), 32'(!legal(cur_size, cur_addr)));
        end else begin
          check("err_without_done", 32'(err), 32'd0);
        end
      end
    end
  end

  // ---------------- directed store ----------------
  task automatic run_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] old, input int unsigned dly,
                           input int unsigned lit_lat, input logic [31:0] lit_wdata,
                           input logic lit_err, input logic [3:0] lit_be);
    int unsigned t_acc;
    int unsigned lat;
    bit seen;
    cur_size = s; cur_addr = a; cur_wd = wd; cur_old = old; ack_dly = dly;
    rd_cycles = 0; wr_cycles = 0; done_cnt = 0; last_wdata = 32'h0; last_err = 1'b0;
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_size = s; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    t_acc = cyc;
    in_flight = 1'b1;
    req_valid = 1'b0; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    lat = cyc - t_acc + 1;
    check("latency_model", lat, 32'(phases(s, a) * int'(dly + 1) + 1));
    check("latency_lit", lat, lit_lat);
    @(posedge clk); #1;
    in_flight = 1'b0;
    check("done_pulses", done_cnt, 32'd1);
    check("rd_phase", 32'(rd_cycles != 0), 32'(phases(s, a) == 2));
    check("wr_phase", 32'(wr_cycles != 0), 32'(phases(s, a) >= 1));
    check("err_lit", 32'(last_err), 32'(lit_err));
    if (!lit_err) begin
      check("wdata_lit", last_wdata, lit_wdata);
`ifdef SNR_BYTE_STROBE_EN
      check("be_lit", 32'(last_be), 32'(lit_be));
`endif
    end
  endtask

  task automatic reset_mid_strobe();
    cur_size = 2'd0; cur_addr = 32'h30; cur_wd = 32'h77; cur_old = 32'h0; ack_dly = 10;
    done_cnt = 0;
    req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h30; req_wdata = 32'h77;
    @(posedge clk); #1;
    in_flight = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef SNR_BYTE_STROBE_EN
    check("strobe_before_reset", 32'(mem_wr), 32'd1);
`else
    check("rd_before_reset", 32'(mem_rd), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_addr", mem_addr, 32'h0);
    in_flight = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_no_done", done_cnt, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; in_flight = 1'b0; spur = 1'b0; ack_dly = 0;
    cur_size = 2'd0; cur_addr = 32'h0; cur_wd = 32'h0; cur_old = 32'h0;
    rd_cycles = 0; wr_cycles = 0; done_cnt = 0; last_wdata = 32'h0; last_err = 1'b0;
    req_valid = 1'b0; req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    check("rst_done_err", {30'h0, done, err}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
`ifdef SNR_BYTE_STROBE_EN
    check("rst_be", 32'(mem_be), 32'h0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef SNR_BYTE_STROBE_EN
    run_store(2'd0, 32'h0000_0041, 32'h0000_005A, 32'h0, 0, 2, 32'h5A5A_5A5A, 1'b0, 4'b0010);
    run_store(2'd1, 32'h0000_0006, 32'hFFFF_CAFE, 32'h0, 1, 3, 32'hCAFE_CAFE, 1'b0, 4'b1100);
    run_store(2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2, 4, 32'hDEAD_BEEF, 1'b0, 4'b1111);
    reset_mid_strobe();
    run_store(2'd0, 32'h0000_0043, 32'h1234_56C7, 32'h0, 0, 2, 32'hC7C7_C7C7, 1'b0, 4'b1000);
`else
    run_store(2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 0, 2, 32'hDEAD_BEEF, 1'b0, 4'h0);
    run_store(2'd0, 32'h0000_0023, 32'h1234_56AB, 32'h1111_1111, 3, 9, 32'hAB11_1111, 1'b0, 4'h0);
    run_store(2'd1, 32'h0000_0006, 32'hFFFF_CAFE, 32'h0102_0304, 0, 3, 32'hCAFE_0304, 1'b0, 4'h0);
    run_store(2'd0, 32'h0000_0020, 32'h0000_00C3, 32'hA5A5_A5A5, 1, 5, 32'hA5A5_A5C3, 1'b0, 4'h0);
    reset_mid_strobe();
    run_store(2'd1, 32'h0000_0004, 32'h0000_1234, 32'hFFFF_FFFF, 2, 7, 32'hFFFF_1234, 1'b0, 4'h0);
    run_store(2'd0, 32'h0000_0049, 32'hFFFF_FF00, 32'h8765_4321, 0, 3, 32'h8765_0021, 1'b0, 4'h0);
`endif
    // rejected requests: done & err at T+1, no memory access
    run_store(2'd1, 32'h0000_0005, 32'h0000_BEEF, 32'h0, 0, 1, 32'h0, 1'b1, 4'h0);
    run_store(2'd2, 32'h0000_0002, 32'h1234_5678, 32'h0, 0, 1, 32'h0, 1'b1, 4'h0);
    run_store(2'd3, 32'h0000_0008, 32'h1234_5678, 32'h0, 0, 1, 32'h0, 1'b1, 4'h0);

    // spurious ack while idle must be ignored
    done_cnt = 0;
    spur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("spur_ready", 32'(req_ready), 32'd1);
    check("spur_quiet", {29'h0, mem_rd, mem_wr, done}, 32'h0);

    run_store(2'd2, 32'h0000_0100, 32'h0BAD_F00D, 32'h0, 0, 2, 32'h0BAD_F00D, 1'b0, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-path narrowing unit for the MIPS data memory: truncates the 32-bit register value (rt) to byte, halfword or word and writes it to its lane of a word-wide data memory.
- Performs read-modify-write over a simple req/ack memory interface, because the memory has no byte strobes.
- Sits between the store-control datapath and the data memory; it is the write-direction counterpart of the immediate/load extension logic.

Parameters:
- ADDR_W, 32, byte-address width (data width is fixed at 32)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  register data; only the low bits are used for byte/half stores
- mem_addr  out  ADDR_W  word address {req_addr[ADDR_W-1:2], 2'b00}, registered
- mem_rd  out  1  memory read strobe, held until mem_ack
- mem_wr  out  1  memory write strobe, held until mem_ack
- mem_wdata  out  32  merged write word, registered
- mem_rdata  in  32  read data, valid when mem_ack is high during RD
- mem_ack  in  1  memory completion, single-cycle pulse
- done  out  1  one-cycle pulse when the store completes
- err  out  1  one-cycle pulse, coincident with done, on a rejected request

Behaviour:
- Reset (rst_n low, async): state = IDLE, mem_rd = mem_wr = done = err = 0, mem_addr = 0, mem_wdata = 0. req_ready = 1 because it is decoded from IDLE. A reset in any state aborts the operation with no done pulse.
- Accept: req_valid & req_ready on a rising edge latches addr, size and wdata.
- Misalign/reserved check at accept:
  - rejected if size = 11, or half with addr[0] = 1, or word with addr[1:0] != 0
  - on reject: go to DONE with err = 1; no memory access is issued
- States:
  - IDLE
  - RD: mem_rd = 1; on mem_ack capture mem_rdata, merge, go to WR
  - WR: mem_wr = 1 with mem_wdata = merged word; on mem_ack go to DONE
  - DONE: done = 1 for one cycle (err as set at accept); then IDLE
- Routing: word store goes IDLE -> WR directly with mem_wdata = req_wdata. Byte/half store goes IDLE -> RD -> WR.
- Lane merge (little-endian lanes):
  - byte k = addr[1:0]: bits [8k+7:8k] = wdata[7:0]
  - half h = addr[1]: bits [16h+15:16h] = wdata[15:0]
  - all other bits come from the captured read word
- Timing:
  - mem_ack may arrive in the first strobe cycle; that is the minimum 1-cycle wait.
  - Minimum latency from accept edge T: word store has done at T+2; byte/half store has done at T+3.
- mem_ack outside RD/WR is ignored. A strobe never deasserts before its ack.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE), never during DONE.
- req_* inputs are don't-care while req_ready = 0.

Optional Feature:
- Macro: SNR_BYTE_STROBE_EN.
- Defined:
  - adds output mem_be [3:0], registered, reset 0
  - RD is never entered; all stores go IDLE -> WR -> DONE
  - mem_wdata holds the truncated data replicated to all lanes (byte x4, half x2)
  - mem_be selects the lanes: byte = 1 << addr[1:0]; half = 0011 or 1100; word = 1111
  - mem_rd stays 0
- Not defined: read-modify-write as above, and no mem_be port.

Test Plan:
- Reset mid-RD: assert rst_n = 0 while mem_rd = 1 -> mem_rd drops immediately, done never pulses, req_ready = 1 after release.
- Word store: addr 0x0000_0010, wdata 0xDEAD_BEEF, ack in first strobe cycle -> no mem_rd; mem_wr with mem_addr 0x10 and mem_wdata 0xDEADBEEF; done at T+2.
- Byte store: addr 0x0000_0023, wdata 0x1234_56AB, mem_rdata 0x1111_1111, ack delayed 3 cycles -> mem_rd then mem_wr to 0x20, mem_wdata 0xAB11_1111, single done pulse.
- Half store: addr 0x0000_0006, wdata 0xFFFF_CAFE, mem_rdata 0x0102_0304 -> mem_wdata 0xCAFE_0304.
- Misaligned: half at 0x0000_0005, then word at 0x0000_0002, then size 11 -> each gives done & err for one cycle at T+1 with no mem_rd/mem_wr.
- SNR_BYTE_STROBE_EN defined: byte at 0x0000_0041, wdata 0x0000_005A -> mem_be 0010, mem_wdata 0x5A5A_5A5A, no read cycle; a spurious mem_ack in IDLE has no effect.
